lockin_sequencer: RTL and testbench

LOCKIN_SEQUENCER -- requirements
Module: lockin_sequencer

---
 rtl/lockin_sequencer.sv | 144 ++++++++++++++
 tb/tb_lockin_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockin_sequencer.sv
// Lock-in measurement sequencer: configures, arms and runs the I/Q datapath, counting result pairs.
// All outputs registered one cycle after the deciding input; no backpressure, abort wins over everything.
module lockin_sequencer #(
   parameter int unsigned CFG_HOLD = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] cfg_ptos_x_ciclo,
   input  logic [31:0] cfg_frames,
   input  logic [31:0] cfg_n_results,
   input  logic [31:0] cfg_timeout,
   input  logic        ready_to_calculate,
   input  logic        data_out1_valid,
   input  logic        data_out2_valid,
   output logic        proc_reset_n,
   output logic        proc_enable,
   output logic [31:0] param_0,
   output logic [31:0] param_1,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err_code,
   output logic [31:0] result_count,
   output logic [2:0]  state
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CONFIG = 3'd1,
      S_ARM    = 3'd2,
      S_RUN    = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   localparam logic [7:0] LP_HOLD_LAST = 8'(CFG_HOLD - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cfg_cnt;
   logic [31:0] r_tmo;
   logic [31:0] r_n_results;
   logic [31:0] r_timeout;
   logic [31:0] w_tmo_inc;
   logic [31:0] w_cnt_inc;
   logic        w_pair;
   logic        w_mismatch;
   logic        w_can_start;
   logic        w_start_ok;
   logic        w_start_bad;
   logic        w_tmo_hit;

   assign w_pair      = data_out1_valid & data_out2_valid;
   assign w_mismatch  = data_out1_valid ^ data_out2_valid;
   assign w_tmo_inc   = r_tmo + 32'd1;
   assign w_cnt_inc   = result_count + 32'd1;
   assign w_tmo_hit   = (r_timeout != 32'd0) && (w_tmo_inc == r_timeout);
   assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
   assign w_start_ok  = start & w_can_start & (cfg_n_results != 32'd0);
   assign w_start_bad = start & w_can_start & (cfg_n_results == 32'd0);
   assign state       = r_state;

   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (w_start_ok)              w_next = S_CONFIG;
               else if (w_start_bad)        w_next = S_ERROR;
               else if (r_state == S_DONE)  w_next = S_IDLE;
            end
            S_CONFIG: if (r_cfg_cnt == LP_HOLD_LAST) w_next = S_ARM;
            // Ready beats a same-cycle timeout so a primed datapath is never thrown away.
            S_ARM: begin
               if (ready_to_calculate) w_next = S_RUN;
               else if (w_tmo_hit)     w_next = S_ERROR;
            end
            S_RUN: begin
               if (w_pair) begin
                  if (w_cnt_inc == r_n_results) w_next = S_DONE;
               end else if (w_mismatch) begin
                  w_next = S_ERROR;
               end else if (w_tmo_hit) begin
                  w_next = S_ERROR;
               end
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         proc_reset_n <= 1'b0;
         proc_enable  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_code     <= 2'b00;
         result_count <= 32'd0;
         param_0      <= 32'd0;
         param_1      <= 32'd0;
         r_cfg_cnt    <= 8'd0;
         r_tmo        <= 32'd0;
         r_n_results  <= 32'd0;
         r_timeout    <= 32'd0;
      end else begin
         r_state      <= w_next;
         proc_reset_n <= !((w_next == S_IDLE) || (w_next == S_CONFIG));
         proc_enable  <= (w_next == S_ARM) || (w_next == S_RUN);
         busy         <= (w_next == S_CONFIG) || (w_next == S_ARM) || (w_next == S_RUN);
         done         <= (w_next == S_DONE);

         if (r_state == S_CONFIG) r_cfg_cnt <= r_cfg_cnt + 8'd1;

         if (!abort && w_start_ok) begin
            param_0      <= cfg_ptos_x_ciclo;
            param_1      <= cfg_frames;
            r_n_results  <= cfg_n_results;
            r_timeout    <= cfg_timeout;
            result_count <= 32'd0;
            err_code     <= 2'b00;
            r_cfg_cnt    <= 8'd0;
         end else if (!abort && r_state == S_RUN && w_pair) begin
            result_count <= w_cnt_inc;
         end

         if (!abort && w_start_bad)
            err_code <= 2'b11;
         else if (w_next == S_ERROR && r_state == S_ARM)
            err_code <= 2'b01;
         else if (w_next == S_ERROR && r_state == S_RUN)
            err_code <= w_mismatch ? 2'b10 : 2'b01;

         // Counter restarts at ARM entry and after every accepted pair.
         if (r_state == S_CONFIG)
            r_tmo <= 32'd0;
         else if (r_state == S_ARM || r_state == S_RUN)
            r_tmo <= (r_state == S_RUN && w_pair) ? 32'd0 : w_tmo_inc;
      end
   end
endmodule

// File: tb/tb_lockin_sequencer.sv
// Bench for lockin_sequencer: nominal vector table, directed corner sequences, randomized run vs model.
module tb_lockin_sequencer;
   logic        clk = 1'b0;
   logic        reset_n, start, abort, ready_to_calculate, data_out1_valid, data_out2_valid;
   logic [31:0] cfg_ptos_x_ciclo, cfg_frames, cfg_n_results, cfg_timeout;
   logic        proc_reset_n, proc_enable, busy, done;
   logic [31:0] param_0, param_1, result_count;
   logic [1:0]  err_code;
   logic [2:0]  state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lockin_sequencer #(.CFG_HOLD(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .cfg_ptos_x_ciclo(cfg_ptos_x_ciclo), .cfg_frames(cfg_frames),
      .cfg_n_results(cfg_n_results), .cfg_timeout(cfg_timeout),
      .ready_to_calculate(ready_to_calculate),
      .data_out1_valid(data_out1_valid), .data_out2_valid(data_out2_valid),
      .proc_reset_n(proc_reset_n), .proc_enable(proc_enable),
      .param_0(param_0), .param_1(param_1), .busy(busy), .done(done),
      .err_code(err_code), .result_count(result_count), .state(state)
   );

   typedef struct {
      logic        st, ab, rdy, v1, v2;
      logic [2:0]  s;
      logic        prn, en, dn;
      logic [31:0] cnt;
      logic [1:0]  err;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mk(input logic st, ab, rdy, v1, v2, input logic [2:0] s,
                               input logic prn, en, dn, input logic [31:0] cnt, input logic [1:0] err);
      vec_t v;
      v.st = st; v.ab = ab; v.rdy = rdy; v.v1 = v1; v.v2 = v2;
      v.s = s; v.prn = prn; v.en = en; v.dn = dn; v.cnt = cnt; v.err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      start = 0; abort = 0; ready_to_calculate = 0; data_out1_valid = 0; data_out2_valid = 0;
   endtask

   task automatic wait_state(input logic [2:0] s, input string nm);
      int k = 0;
      while (state !== s && k < 50) begin
         step();
         k++;
      end
      chk(nm, state, s);
   endtask

   task automatic begin_run(input logic [31:0] n, input logic [31:0] to);
      cfg_n_results = n; cfg_timeout = to; start = 1;
      step();
      start = 0;
      wait_state(3'd2, "reach_arm");
      ready_to_calculate = 1;
      step();
      ready_to_calculate = 0;
      chk("enter_run", state, 3'd3);
   endtask

   // Reference model state
   logic [2:0]  m_st;
   logic [1:0]  m_err;
   logic [31:0] m_cnt, m_n, m_to, m_p0, m_p1;
   int          m_edge, m_arm_at, m_mark;

   task automatic model_step();
      int e = m_edge + 1;
      if (abort) m_st = 3'd0;
      else case (m_st)
         3'd0, 3'd4, 3'd5: begin
            if (start && cfg_n_results != 0) begin
               m_p0 = cfg_ptos_x_ciclo; m_p1 = cfg_frames; m_n = cfg_n_results; m_to = cfg_timeout;
               m_cnt = 0; m_err = 0; m_st = 3'd1; m_arm_at = e + 4;
            end else if (start) begin
               m_st = 3'd5; m_err = 2'b11;
            end else if (m_st == 3'd4) m_st = 3'd0;
         end
         3'd1: if (e == m_arm_at) begin m_st = 3'd2; m_mark = e; end
         3'd2: begin
            if (ready_to_calculate) m_st = 3'd3;
            else if (m_to != 0 && (e - m_mark) == int'(m_to)) begin m_st = 3'd5; m_err = 2'b01; end
         end
         3'd3: begin
            if (data_out1_valid && data_out2_valid) begin
               m_cnt++; m_mark = e;
               if (m_cnt == m_n) m_st = 3'd4;
            end else if (data_out1_valid != data_out2_valid) begin
               m_st = 3'd5; m_err = 2'b10;
            end else if (m_to != 0 && (e - m_mark) == int'(m_to)) begin
               m_st = 3'd5; m_err = 2'b01;
            end
         end
         default: m_st = 3'd0;
      endcase
      m_edge = e;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lowcnt, done_cnt, k;
      logic rose;
      logic [31:0] rv;
      clr_in();
      cfg_ptos_x_ciclo = 0; cfg_frames = 0; cfg_n_results = 0; cfg_timeout = 0;
      reset_n = 0;
      #2;
      chk("rst_state", state, 3'd0);
      chk("rst_outs", {proc_reset_n, proc_enable, busy, done, err_code}, 6'd0);
      chk("rst_regs", {result_count, param_0, param_1}, 96'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1;

      // Nominal run: CFG_HOLD=4, three pairs, ready two cycles into ARM
      tbl[0]  = mk(1,0,0,0,0, 3'd1, 0,0,0, 0, 0);
      tbl[1]  = mk(0,0,0,0,0, 3'd1, 0,0,0, 0, 0);
      tbl[2]  = mk(0,0,0,0,0, 3'd1, 0,0,0, 0, 0);
      tbl[3]  = mk(0,0,0,0,0, 3'd1, 0,0,0, 0, 0);
      tbl[4]  = mk(0,0,0,0,0, 3'd2, 1,1,0, 0, 0);
      tbl[5]  = mk(0,0,0,0,0, 3'd2, 1,1,0, 0, 0);
      tbl[6]  = mk(0,0,0,0,0, 3'd2, 1,1,0, 0, 0);
      tbl[7]  = mk(0,0,1,0,0, 3'd3, 1,1,0, 0, 0);
      tbl[8]  = mk(0,0,0,1,1, 3'd3, 1,1,0, 1, 0);
      tbl[9]  = mk(1,0,0,0,0, 3'd3, 1,1,0, 1, 0);
      tbl[10] = mk(0,0,0,1,1, 3'd3, 1,1,0, 2, 0);
      tbl[11] = mk(0,0,0,1,1, 3'd4, 1,0,1, 3, 0);
      tbl[12] = mk(0,0,0,0,0, 3'd0, 0,0,0, 3, 0);
      tbl[13] = mk(0,0,0,0,0, 3'd0, 0,0,0, 3, 0);
      cfg_ptos_x_ciclo = 32'h1234_5678; cfg_frames = 32'h0000_00C8;
      cfg_n_results = 3; cfg_timeout = 0;
      lowcnt = 0; done_cnt = 0; rose = 0;
      for (int i = 0; i < 14; i++) begin
         start = tbl[i].st; abort = tbl[i].ab; ready_to_calculate = tbl[i].rdy;
         data_out1_valid = tbl[i].v1; data_out2_valid = tbl[i].v2;
         if (i == 0 && proc_reset_n === 1'b0) lowcnt++;
         step();
         if (i == 1) begin cfg_ptos_x_ciclo = 32'hDEAD_BEEF; cfg_frames = 32'h5555_AAAA; end
         if (!rose && proc_reset_n === 1'b0) lowcnt++;
         if (proc_reset_n === 1'b1) rose = 1;
         if (done === 1'b1) done_cnt++;
         chk($sformatf("nom%0d_state", i), state, tbl[i].s);
         chk($sformatf("nom%0d_prn_en_done", i), {proc_reset_n, proc_enable, done},
             {tbl[i].prn, tbl[i].en, tbl[i].dn});
         chk($sformatf("nom%0d_count", i), result_count, tbl[i].cnt);
         chk($sformatf("nom%0d_err", i), err_code, tbl[i].err);
      end
      clr_in();
      chk("nom_prn_low_cycles", lowcnt, 5);
      chk("nom_done_pulses", done_cnt, 1);
      chk("nom_params_held", {param_0, param_1}, {32'h1234_5678, 32'h0000_00C8});

      // Timeout with ready never asserted
      cfg_n_results = 2; cfg_timeout = 10; start = 1;
      step();
      start = 0;
      wait_state(3'd2, "to_reach_arm");
      k = 0;
      while (state === 3'd2 && k < 30) begin step(); k++; end
      chk("to_cycles_in_arm", k, 10);
      chk("to_state", state, 3'd5);
      chk("to_err", err_code, 2'b01);
      chk("to_enable", {proc_enable, proc_reset_n}, 2'b01);

      // Mismatch after two good pairs
      begin_run(5, 0);
      data_out1_valid = 1; data_out2_valid = 1;
      step(); step();
      data_out2_valid = 0;
      step();
      data_out1_valid = 0;
      chk("mm_state", state, 3'd5);
      chk("mm_err", err_code, 2'b10);
      chk("mm_count", result_count, 32'd2);
      step();
      chk("mm_persist", {state, result_count}, {3'd5, 32'd2});

      // Abort and start together in RUN
      begin_run(5, 0);
      data_out1_valid = 1; data_out2_valid = 1;
      step();
      data_out1_valid = 0; data_out2_valid = 0;
      abort = 1; start = 1;
      step();
      abort = 0; start = 0;
      chk("ab_state", state, 3'd0);
      chk("ab_prn_done", {proc_reset_n, done, proc_enable}, 3'b000);
      chk("ab_count_err", {result_count, err_code}, {32'd1, 2'b00});
      done_cnt = 0;
      repeat (3) begin step(); if (done === 1'b1) done_cnt++; end
      chk("ab_no_done", {done_cnt, 29'd0, state}, {32'd0, 29'd0, 3'd0});

      // Bad configuration then a good single-pair run
      cfg_n_results = 0; start = 1;
      step();
      start = 0;
      chk("bad_state_err", {state, err_code}, {3'd5, 2'b11});
      begin_run(1, 0);
      chk("good_err_cleared", err_code, 2'b00);
      data_out1_valid = 1; data_out2_valid = 1;
      step();
      data_out1_valid = 0; data_out2_valid = 0;
      chk("good_done", {state, done, result_count}, {3'd4, 1'b1, 32'd1});
      step();
      chk("good_idle", {state, done, result_count}, {3'd0, 1'b0, 32'd1});

      // Asynchronous reset in the middle of RUN
      cfg_ptos_x_ciclo = 32'h0000_0F0F; cfg_frames = 32'h0000_0707;
      begin_run(4, 0);
      data_out1_valid = 1; data_out2_valid = 1;
      step();
      data_out1_valid = 0; data_out2_valid = 0;
      #2 reset_n = 0;
      #1;
      chk("arst_state", state, 3'd0);
      chk("arst_outs", {proc_reset_n, proc_enable, busy, done, err_code}, 6'd0);
      chk("arst_regs", {result_count, param_0, param_1}, 96'd0);
      step();
      reset_n = 1;
      step();
      chk("arst_idle_after", {state, busy}, {3'd0, 1'b0});

      // Randomized traffic against the model
      reset_n = 0;
      step();
      reset_n = 1;
      m_st = 0; m_err = 0; m_cnt = 0; m_n = 0; m_to = 0; m_p0 = 0; m_p1 = 0;
      m_edge = 0; m_arm_at = 0; m_mark = 0;
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 9) == 0);
         abort = ($urandom_range(0, 59) == 0);
         ready_to_calculate = ($urandom_range(0, 3) == 0);
         rv = $urandom_range(0, 19);
         data_out1_valid = (rv <= 6);
         data_out2_valid = (rv <= 5) || (rv == 7);
         cfg_n_results = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 4));
         cfg_timeout = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(2, 12));
         cfg_ptos_x_ciclo = $urandom;
         cfg_frames = $urandom;
         model_step();
         step();
         chk($sformatf("rand%0d", c),
             {state, proc_reset_n, proc_enable, busy, done, err_code, result_count, param_0, param_1},
             {m_st, !(m_st == 3'd0 || m_st == 3'd1), (m_st == 3'd2 || m_st == 3'd3),
              (m_st == 3'd1 || m_st == 3'd2 || m_st == 3'd3), (m_st == 3'd4), m_err, m_cnt, m_p0, m_p1});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
